inst_encoder: RTL and testbench

Assembles RV32I instruction words from decoded-field descriptors and streams them into instruction memory through a write port with backpressure. This is the encoder counterpart of the pipeline's control/decode logic. It is used by the boot/test loader to program imem from a host or scripted source. Each descriptor is encoded into one 32-bit word (opcode, funct3/funct7, register fields, type-specific immediate packing) and written to a sequential word address.

---
 rtl/inst_encoder.sv | 176 +++++++++++++++++
 tb/tb_inst_encoder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
//==============================================================================
// Module   : inst_encoder
// Brief    : Packs RV32I descriptors into instruction words and streams them
//            to a sequential imem write port with backpressure.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              desc_valid_i,
    output logic              desc_ready_o,
    input  logic [3:0]        class_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic              alt_i,
    input  logic [31:0]       imm_i,
    input  logic              last_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic              imem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W+1:0] c_CAP      = {1'b0, 1'b1, {ADDR_W{1'b0}}};

    state_t              r_state, w_state_nxt;
    logic                r_out_valid;
    logic                r_out_last;
    logic [31:0]         r_wdata;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;

    logic                w_ready, w_accept, w_wr_done, w_illegal, w_full;
    logic [31:0]         w_enc;
    logic [ADDR_W+1:0]   w_inflight;
    logic                w_sx11, w_sx12, w_sx20, w_shift;

    // A registered last word blocks intake so nothing slips in behind it.
    assign w_ready   = (r_state == S_RUN) & (~r_out_valid | (imem_ready_i & ~r_out_last));
    assign w_accept  = desc_valid_i & w_ready;
    assign w_wr_done = r_out_valid & imem_ready_i;

    // Any pending word completes in the acceptance cycle, so it is counted here.
    assign w_inflight = {1'b0, r_count} + {{(ADDR_W+1){1'b0}}, r_out_valid};
    assign w_full     = (w_inflight >= c_CAP);

    assign w_sx11  = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign w_sx12  = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign w_sx20  = (&imm_i[31:20]) | ~(|imm_i[31:20]);
    assign w_shift = (funct3_i == 3'b001) | (funct3_i == 3'b101);

    always_comb begin
        w_enc     = 32'h0;
        w_illegal = w_full;
        case (class_i)
            4'd0: w_enc = {(alt_i ? 7'b0100000 : 7'b0000000), rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
            4'd1: begin
                if (w_shift)
                    w_enc = {1'b0, alt_i, 5'b00000, imm_i[4:0], rs1_i, funct3_i, rd_i, 7'b0010011};
                else
                    w_enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
                w_illegal = w_full | ~w_sx11;
            end
            4'd2: begin
                w_enc     = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
                w_illegal = w_full | ~w_sx11 | (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11);
            end
            4'd3: begin
                w_enc     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
                w_illegal = w_full | ~w_sx11 | (funct3_i > 3'b010);
            end
            4'd4: begin
                w_enc     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], 7'b1100011};
                w_illegal = w_full | ~w_sx12 | imm_i[0] | (funct3_i[2:1] == 2'b01);
            end
            4'd5: begin
                w_enc     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
                w_illegal = w_full | ~w_sx20 | imm_i[0];
            end
            4'd6: begin
                w_enc     = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b1100111};
                w_illegal = w_full | ~w_sx11;
            end
            4'd7: begin
                w_enc     = {imm_i[31:12], rd_i, 7'b0110111};
                w_illegal = w_full | (|imm_i[11:0]);
            end
            4'd8: begin
                w_enc     = {imm_i[31:12], rd_i, 7'b0010111};
                w_illegal = w_full | (|imm_i[11:0]);
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start_i) begin
            w_state_nxt = S_RUN;
        end else if (r_state == S_RUN) begin
            if (w_accept && w_illegal)
                w_state_nxt = S_ERR;
            else if (w_wr_done && r_out_last)
                w_state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_wdata     <= 32'h0;
            r_addr      <= c_BASE;
            r_count     <= '0;
        end else if (start_i) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_addr      <= c_BASE;
            r_count     <= '0;
        end else begin
            if (w_wr_done) begin
                r_addr  <= r_addr + c_ADDR_ONE;
                r_count <= r_count + c_CNT_ONE;
            end
            if (w_accept && !w_illegal) begin
                r_out_valid <= 1'b1;
                r_out_last  <= last_i;
                r_wdata     <= w_enc;
            end else if (w_wr_done) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign desc_ready_o = w_ready;
    assign imem_we_o    = r_out_valid;
    assign imem_addr_o  = r_addr;
    assign imem_wdata_o = r_wdata;
    assign count_o      = r_count;
    assign busy_o       = (r_state == S_RUN);
    assign done_o       = (r_state == S_DONE);
    assign err_o        = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
//==============================================================================
// Module   : tb_inst_encoder
// Brief    : Directed self-checking bench for inst_encoder (default and
//            2-bit address instances sharing one stimulus stream).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_inst_encoder;

    typedef struct packed {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
        logic        last;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        desc_valid_i = 1'b0;
    logic [3:0]  class_i = '0;
    logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic        alt_i = 1'b0;
    logic [31:0] imm_i = '0;
    logic        last_i = 1'b0;
    logic        imem_ready_i = 1'b1;

    logic        desc_ready_o, imem_we_o, busy_o, done_o, err_o;
    logic [9:0]  imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic [10:0] count_o;

    logic        d2_ready, d2_we, d2_busy, d2_done, d2_err;
    logic [1:0]  d2_addr;
    logic [31:0] d2_wdata;
    logic [2:0]  d2_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .class_i(class_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .alt_i(alt_i), .imm_i(imm_i), .last_i(last_i),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .imem_ready_i(imem_ready_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .count_o(count_o)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(d2_ready),
        .class_i(class_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .alt_i(alt_i), .imm_i(imm_i), .last_i(last_i),
        .imem_we_o(d2_we), .imem_addr_o(d2_addr), .imem_wdata_o(d2_wdata),
        .imem_ready_i(imem_ready_i), .busy_o(d2_busy), .done_o(d2_done),
        .err_o(d2_err), .count_o(d2_count)
    );

    function automatic desc_t mk(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                                 input logic [31:0] imm, input logic last);
        mk = '{cls: c, rd: rd, rs1: rs1, rs2: rs2, f3: f3, alt: alt, imm: imm, last: last};
    endfunction

    task automatic drive(input desc_t d);
        class_i = d.cls; rd_i = d.rd; rs1_i = d.rs1; rs2_i = d.rs2;
        funct3_i = d.f3; alt_i = d.alt; imm_i = d.imm; last_i = d.last;
        desc_valid_i = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({imem_we_o, busy_o, done_o, err_o, desc_ready_o, imem_addr_o, count_o, imem_wdata_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got we=%b busy=%b done=%b err=%b rdy=%b addr=%0d cnt=%0d wd=%h, want all 0",
                     imem_we_o, busy_o, done_o, err_o, desc_ready_o, imem_addr_o, count_o, imem_wdata_o);
        end
        @(negedge clk) rst_ni = 1'b1;
        drive(mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1));
        @(negedge clk);
        n_cmp++;
        if ({desc_ready_o, imem_we_o, busy_o, d2_ready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_no_accept: got rdy=%b we=%b busy=%b rdy2=%b, want 0000",
                     desc_ready_o, imem_we_o, busy_o, d2_ready);
        end
        desc_valid_i = 1'b0;
    endtask

    task automatic test_single();
        pulse_start();
        drive(mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1));
        @(negedge clk);
        n_cmp++;
        if ({busy_o, desc_ready_o} !== 2'b11) begin
            n_bad++;
            $display("FAIL run_ready: got busy=%b rdy=%b, want 1 1", busy_o, desc_ready_o);
        end
        @(posedge clk); #1 desc_valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({imem_we_o, imem_addr_o, imem_wdata_o} !== {1'b1, 10'd0, 32'h00500093}) begin
            n_bad++;
            $display("FAIL single_word: got we=%b addr=%0d wd=%h, want 1 0 00500093",
                     imem_we_o, imem_addr_o, imem_wdata_o);
        end
        @(negedge clk);
        n_cmp++;
        if ({done_o, busy_o, imem_we_o, desc_ready_o, count_o} !== {4'b1000, 11'd1}) begin
            n_bad++;
            $display("FAIL single_done: got done=%b busy=%b we=%b rdy=%b cnt=%0d, want 1 0 0 0 1",
                     done_o, busy_o, imem_we_o, desc_ready_o, count_o);
        end
    endtask

    task automatic run_stream(input string name, input desc_t d[], input logic [31:0] w[]);
        pulse_start();
        for (int i = 0; i < d.size(); i++) begin
            drive(d[i]);
            @(posedge clk); #1 desc_valid_i = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({imem_we_o, imem_addr_o, imem_wdata_o} !== {1'b1, 10'(i), w[i]}) begin
                n_bad++;
                $display("FAIL %s[%0d]: got we=%b addr=%0d wd=%h, want 1 %0d %h",
                         name, i, imem_we_o, imem_addr_o, imem_wdata_o, i, w[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done_o, imem_we_o, count_o} !== {2'b10, 11'(d.size())}) begin
            n_bad++;
            $display("FAIL %s_done: got done=%b we=%b cnt=%0d, want 1 0 %0d",
                     name, done_o, imem_we_o, count_o, d.size());
        end
    endtask

    task automatic test_back_to_back();
        desc_t d[] = '{mk(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0),
                       mk(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1'b0),
                       mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC, 1'b1)};
        logic [31:0] w[] = '{32'h402081B3, 32'h0020A423, 32'hFE208EE3};
        run_stream("b2b", d, w);
    endtask

    task automatic test_encodings();
        desc_t d[] = '{mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000800, 1'b0),
                       mk(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b0),
                       mk(4'd1, 5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 32'd3, 1'b0),
                       mk(4'd6, 5'd1, 5'd2, 5'd0, 3'd7, 1'b0, 32'hFFFFFFF8, 1'b0),
                       mk(4'd2, 5'd4, 5'd3, 5'd0, 3'd2, 1'b0, 32'hFFFFFFFF, 1'b0),
                       mk(4'd8, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF000, 1'b0),
                       mk(4'd1, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'hFFFFF800, 1'b1)};
        logic [31:0] w[] = '{32'h001000EF, 32'h123452B7, 32'h40335293, 32'hFF8100E7,
                             32'hFFF1A203, 32'hFFFFF397, 32'h80008093};
        run_stream("enc", d, w);
    endtask

    task automatic test_backpressure();
        pulse_start();
        imem_ready_i = 1'b0;
        drive(mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0));
        @(posedge clk); #1 drive(mk(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b1));
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({imem_we_o, desc_ready_o, imem_addr_o, imem_wdata_o, count_o} !==
                {2'b10, 10'd0, 32'h00500093, 11'd0}) begin
                n_bad++;
                $display("FAIL stall[%0d]: got we=%b rdy=%b addr=%0d wd=%h cnt=%0d, want 1 0 0 00500093 0",
                         j, imem_we_o, desc_ready_o, imem_addr_o, imem_wdata_o, count_o);
            end
        end
        imem_ready_i = 1'b1;
        @(posedge clk); #1 desc_valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({imem_we_o, imem_addr_o, imem_wdata_o, count_o} !== {1'b1, 10'd1, 32'h123452B7, 11'd1}) begin
            n_bad++;
            $display("FAIL stall_second: got we=%b addr=%0d wd=%h cnt=%0d, want 1 1 123452b7 1",
                     imem_we_o, imem_addr_o, imem_wdata_o, count_o);
        end
        @(negedge clk);
        n_cmp++;
        if ({done_o, imem_we_o, count_o} !== {2'b10, 11'd2}) begin
            n_bad++;
            $display("FAIL stall_done: got done=%b we=%b cnt=%0d, want 1 0 2", done_o, imem_we_o, count_o);
        end
    endtask

    task automatic test_illegal_branch();
        pulse_start();
        drive(mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0));
        @(posedge clk); #1 drive(mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, 1'b0));
        @(posedge clk); #1 drive(mk(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7, 1'b0));
        @(negedge clk);
        n_cmp++;
        if ({err_o, busy_o, imem_we_o, desc_ready_o, count_o} !== {4'b1000, 11'd1}) begin
            n_bad++;
            $display("FAIL illegal_err: got err=%b busy=%b we=%b rdy=%b cnt=%0d, want 1 0 0 0 1",
                     err_o, busy_o, imem_we_o, desc_ready_o, count_o);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({err_o, imem_we_o, count_o} !== {2'b10, 11'd1}) begin
            n_bad++;
            $display("FAIL illegal_hold: got err=%b we=%b cnt=%0d, want 1 0 1", err_o, imem_we_o, count_o);
        end
        desc_valid_i = 1'b0;
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if ({busy_o, err_o, imem_we_o, imem_addr_o, count_o} !== {3'b100, 10'd0, 11'd0}) begin
            n_bad++;
            $display("FAIL restart: got busy=%b err=%b we=%b addr=%0d cnt=%0d, want 1 0 0 0 0",
                     busy_o, err_o, imem_we_o, imem_addr_o, count_o);
        end
    endtask

    task automatic test_legality();
        desc_t d[] = '{mk(4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0),
                       mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000800, 1'b0),
                       mk(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345001, 1'b0),
                       mk(4'd2, 5'd1, 5'd0, 5'd0, 3'd3, 1'b0, 32'd0, 1'b0),
                       mk(4'd3, 5'd0, 5'd1, 5'd2, 3'd3, 1'b0, 32'd0, 1'b0),
                       mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000801, 1'b0),
                       mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1'b0),
                       mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'h00001000, 1'b0),
                       mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd1, 1'b0, 32'hFFFFF000, 1'b0),
                       mk(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'hFFFFF800, 1'b0),
                       mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFF00000, 1'b0),
                       mk(4'd2, 5'd1, 5'd0, 5'd0, 3'd4, 1'b0, 32'h000007FF, 1'b0)};
        logic exp_err[] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < d.size(); i++) begin
            pulse_start();
            drive(d[i]);
            @(posedge clk); #1 desc_valid_i = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({err_o, imem_we_o} !== {exp_err[i], ~exp_err[i]}) begin
                n_bad++;
                $display("FAIL legality[%0d]: got err=%b we=%b, want err=%b we=%b",
                         i, err_o, imem_we_o, exp_err[i], ~exp_err[i]);
            end
        end
    endtask

    task automatic test_wrap();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            drive(mk(4'd1, 5'(i + 1), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i), 1'b0));
            @(posedge clk); #1 desc_valid_i = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({d2_we, d2_addr, d2_err} !== {1'b1, 2'(i), 1'b0}) begin
                n_bad++;
                $display("FAIL wrap_word[%0d]: got we=%b addr=%0d err=%b, want 1 %0d 0",
                         i, d2_we, d2_addr, d2_err, i);
            end
        end
        drive(mk(4'd1, 5'd9, 5'd0, 5'd0, 3'd0, 1'b0, 32'd9, 1'b0));
        @(posedge clk); #1 desc_valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({d2_err, d2_we, d2_addr, d2_count} !== {2'b10, 2'd0, 3'd4}) begin
            n_bad++;
            $display("FAIL wrap_full: got err=%b we=%b addr=%0d cnt=%0d, want 1 0 0 4",
                     d2_err, d2_we, d2_addr, d2_count);
        end
    endtask

    task automatic test_reset_midwrite();
        pulse_start();
        imem_ready_i = 1'b0;
        drive(mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0));
        @(posedge clk); #1 desc_valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (imem_we_o !== 1'b1) begin
            n_bad++;
            $display("FAIL midwrite_pending: got we=%b, want 1", imem_we_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({imem_we_o, busy_o, done_o, err_o, imem_addr_o, count_o} !== '0) begin
            n_bad++;
            $display("FAIL midwrite_reset: got we=%b busy=%b done=%b err=%b addr=%0d cnt=%0d, want all 0",
                     imem_we_o, busy_o, done_o, err_o, imem_addr_o, count_o);
        end
        @(negedge clk) rst_ni = 1'b1;
        imem_ready_i = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_encodings();
        test_backpressure();
        test_illegal_branch();
        test_legality();
        test_wrap();
        test_reset_midwrite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
